digit_scan_mux: RTL



---
 rtl/digit_scan_pkg.sv | 26 ++
 rtl/scan_prescaler.sv | 39 +++
 rtl/digit_scan_mux.sv | 110 +++++++++++
 3 files changed

// File: rtl/digit_scan_pkg.sv
// Shared types and defaults for the digit scan multiplexer family.
// Holds the sequencer state type, default sizing constants and the
// active-low one-hot helper used to drive the channel enables.
package digit_scan_pkg;

  localparam int unsigned DEF_NCH          = 4;
  localparam int unsigned DEF_DW           = 4;
  localparam int unsigned DEF_PRESCALE     = 50000;
  localparam int unsigned DEF_BLANK_CYCLES = 16;
  localparam int unsigned MAX_NCH          = 16;

  typedef enum logic {
    SCAN  = 1'b0,
    BLANK = 1'b1
  } scan_state_e;

  // All ones except a single zero at position idx; callers truncate to
  // their own channel count.
  function automatic logic [MAX_NCH-1:0] onehot_n(input logic [3:0] idx);
    logic [MAX_NCH-1:0] v;
    v      = '1;
    v[idx] = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running prescale counter with synchronous clear.
// cnt runs 0..PRESCALE-1; tc flags the terminal-count cycle combinationally
// and tick is its registered one-cycle pulse. The first enabled edge after a
// clear (or reset) holds cnt at 0, so the first terminal count arrives a full
// PRESCALE cycles after clr drops.
module scan_prescaler #(
  parameter  int unsigned PRESCALE = 4,
  localparam int unsigned CW       = $clog2(PRESCALE)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tc,
  output logic tick
);

  logic [CW-1:0] cnt;
  logic          run;

  assign tc = run && !clr && (cnt == CW'(PRESCALE - 1));

  // Counter, run flag and registered tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      run  <= 1'b0;
      tick <= 1'b0;
    end else begin
      tick <= tc;
      run  <= !clr;
      if (clr || !run || tc) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/digit_scan_mux.sv
// Time-multiplexes NCH data channels onto one DW-bit bus with an active-low
// one-hot channel enable, for driving a shared 7-segment decoder.
// Optional anti-ghosting dead time: define DIGIT_SCAN_MUX_BLANK_EN to insert
// BLANK_CYCLES cycles with all enables off after every channel advance
// (BLANK_CYCLES must be at least 1 and below PRESCALE).
//
// state | meaning
// SCAN  | an_n drives the one-hot enable of the current channel
// BLANK | dead time after an advance; an_n all ones, sel/dout already new
module digit_scan_mux
  import digit_scan_pkg::*;
#(
  parameter  int unsigned NCH          = DEF_NCH,
  parameter  int unsigned DW           = DEF_DW,
  parameter  int unsigned PRESCALE     = DEF_PRESCALE,
  parameter  int unsigned BLANK_CYCLES = DEF_BLANK_CYCLES,
  localparam int unsigned SELW         = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NCH*DW-1:0] din,
  output logic [DW-1:0]     dout,
  output logic [SELW-1:0]   sel,
  output logic [NCH-1:0]    an_n,
  output logic              tick
);

`ifdef DIGIT_SCAN_MUX_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  localparam int unsigned BW = $clog2(PRESCALE);

  logic            tc;
  logic [SELW-1:0] sel_nxt;
  logic [NCH-1:0]  an_next;
  logic [DW-1:0]   dout_next;
  scan_state_e     state;
  logic [BW-1:0]   bcnt;

  scan_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (!en),
    .tc   (tc),
    .tick (tick)
  );

  // Next channel index: advance on terminal count, wrap at NCH-1
  always_comb begin
    sel_nxt = sel;
    if (tc) begin
      sel_nxt = (sel == SELW'(NCH - 1)) ? '0 : sel + SELW'(1);
    end
  end

  // dout/an_n follow the index in effect after the edge
  assign an_next   = NCH'(onehot_n(4'(sel_nxt)));
  assign dout_next = din[sel_nxt*DW +: DW];

  // Channel index, data and enable registers plus the SCAN/BLANK sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SCAN;
      bcnt  <= '0;
      sel   <= '0;
      dout  <= '0;
      an_n  <= '1;
    end else if (!en) begin
      state <= SCAN;
      bcnt  <= '0;
      sel   <= '0;
      dout  <= '0;
      an_n  <= '1;
    end else begin
      sel  <= sel_nxt;
      dout <= dout_next;
      case (state)
        SCAN: begin
          if (BLANK_ON && tc) begin
            state <= BLANK;
            bcnt  <= BW'(BLANK_CYCLES - 1);
            an_n  <= '1;
          end else begin
            an_n <= an_next;
          end
        end
        BLANK: begin
          if (bcnt == '0) begin
            state <= SCAN;
            an_n  <= an_next;
          end else begin
            bcnt <= bcnt - BW'(1);
            an_n <= '1;
          end
        end
        default: begin
          state <= SCAN;
          an_n  <= '1;
        end
      endcase
    end
  end

endmodule
